// File: rtl/matmul_arbiter.sv
// Round-robin front end sharing one 2x2 8-bit matrix multiplier between NREQ requesters.
// Registers the winner's operands, starts the unit, waits for done (or timeout) and returns the result.
//
// state | meaning
// IDLE  | arbitrate pending requests, latch winner operands
// ISSUE | mm_start and gnt to the winner for one cycle
// WAIT  | wait for mm_done or timeout
// RESP  | rsp_valid for one cycle
module matmul_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      gnt,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 mm_start,
    output logic [31:0]          mm_a,
    output logic [31:0]          mm_b,
    input  logic [31:0]          mm_c,
    input  logic                 mm_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    state;
    logic [1:0]    last;
    logic [CW-1:0] cnt;

    logic          found;
    logic [1:0]    win_id;
    logic [31:0]   win_a;
    logic [31:0]   win_b;

    // Scan offsets last+1 .. last+NREQ in order; the first requester hit wins.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        win_a  = '0;
        win_b  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (((int'(last) + off) % NREQ) == j)) begin
                    found  = 1'b1;
                    win_id = 2'(j);
                    win_a  = req_a[32*j +: 32];
                    win_b  = req_b[32*j +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            last     <= 2'(NREQ - 1);
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        mm_a   <= win_a;
                        mm_b   <= win_b;
                        rsp_id <= win_id;
                        last   <= win_id;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // mm_done may still be high from the previous op here; it is not looked at.
                    cnt     <= '0;
                    rsp_err <= 1'b0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mm_done) begin
                        rsp_data <= mm_c;
                        rsp_err  <= 1'b0;
                        state    <= ST_RESP;
                    end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        for (int j = 0; j < NREQ; j++) begin
            gnt[j] = (state == ST_ISSUE) && (rsp_id == 2'(j));
        end
    end

    assign mm_start  = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

endmodule
